// File: rtl/tdma_dispatcher_if.sv
// TDMA dispatcher bus: slot lengths, queue pop handshake,
// downstream valid/ready, slot owner and frame pulse.
interface tdma_dispatcher_if #(
  parameter int NUMBER_OF_QUEUES = 4,
  parameter int REGISTER_SIZE    = 32
);
  localparam int N     = NUMBER_OF_QUEUES;
  localparam int W     = REGISTER_SIZE;
  localparam int SEL_W = $clog2(NUMBER_OF_QUEUES);

  logic [N-1:0][W-1:0] delta;
  logic [N-1:0]        queue_valid;
  logic [N-1:0]        queue_ready;
  logic                out_valid;
  logic                out_ready;
  logic [SEL_W-1:0]    out_queue;
  logic [SEL_W-1:0]    slot;
  logic                frame_start;

  modport slave (
    input  delta, queue_valid, out_ready,
    output queue_ready, out_valid, out_queue,
    output slot, frame_start
  );

  modport master (
    output delta, queue_valid, out_ready,
    input  queue_ready, out_valid, out_queue,
    input  slot, frame_start
  );
endinterface

// File: rtl/tdma_dispatcher.sv
// TDMA dispatcher: slot timer plus IDLE/BUSY grant FSM.
// Ports: clock, reset (async high), bus (slave modport).
module tdma_dispatcher #(
  parameter int NUMBER_OF_QUEUES = 4,
  parameter int REGISTER_SIZE    = 32,
  parameter int WORK_CONSERVING  = 1
) (
  input  logic               clock,
  input  logic               reset,
  tdma_dispatcher_if.slave   bus
);
  localparam int N     = NUMBER_OF_QUEUES;
  localparam int W     = REGISTER_SIZE;
  localparam int SEL_W = $clog2(NUMBER_OF_QUEUES);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] slot_q, slot_d;
  logic [W-1:0]     cnt_q, cnt_d;
  logic [W-1:0]     len_q, len_d;
  logic             first_q, first_d;
  logic             init_q, init_d;
  logic             frame_q, frame_d;
  logic             ov_q, ov_d;
  logic [SEL_W-1:0] oq_q, oq_d;
  logic [SEL_W-1:0] rr_q, rr_d;

  logic [N-1:0]     nz;
  logic [SEL_W-1:0] cur_slot;
  logic [W-1:0]     len;
  logic             owner;
  logic             fb_hit;
  logic [SEL_W-1:0] fb_idx;
  logic             hit;
  logic [SEL_W-1:0] cand;
  logic [N-1:0]     qr;

  function automatic logic [SEL_W-1:0] wrap(
    input int v
  );
    return SEL_W'(v % N);
  endfunction

  // First nonzero-delta index from s (or after s).
  function automatic logic [SEL_W-1:0] nz_from(
    input logic [SEL_W-1:0] s,
    input logic [N-1:0]     m,
    input int               off
  );
    logic [SEL_W-1:0] r;
    logic             f;
    r = s;
    f = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!f && m[wrap(int'(s) + k + off)]) begin
        r = wrap(int'(s) + k + off);
        f = 1'b1;
      end
    end
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < N; i++) begin
      nz[i] = |bus.delta[i];
    end
  end

  // The first cycle after reset resolves the opening slot
  // directly from delta so it can already own that cycle.
  assign cur_slot = init_q ? nz_from('0, nz, 0) : slot_q;
  assign len = (init_q | first_q) ? bus.delta[cur_slot]
                                  : len_q;
  assign owner = |len;

  always_comb begin
    slot_d  = cur_slot;
    cnt_d   = cnt_q + 1'b1;
    len_d   = len;
    first_d = 1'b0;
    frame_d = 1'b0;
    init_d  = 1'b0;
    if (len == '0) begin
      cnt_d   = '0;
      first_d = 1'b1;
      if (|nz) begin
        slot_d  = nz_from(cur_slot, nz, 1);
        frame_d = slot_d <= cur_slot;
      end
    end else if (cnt_q == len - 1'b1) begin
      cnt_d   = '0;
      first_d = 1'b1;
      slot_d  = nz_from(cur_slot, nz, 1);
      frame_d = slot_d <= cur_slot;
    end
  end

  always_comb begin
    fb_hit = 1'b0;
    fb_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (!fb_hit
          && wrap(int'(rr_q) + k) != cur_slot
          && bus.queue_valid[wrap(int'(rr_q) + k)]) begin
        fb_hit = 1'b1;
        fb_idx = wrap(int'(rr_q) + k);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ov_d    = ov_q;
    oq_d    = oq_q;
    rr_d    = rr_q;
    hit     = 1'b0;
    cand    = '0;
    qr      = '0;
    unique case (state_q)
      IDLE: begin
        if (owner && bus.queue_valid[cur_slot]) begin
          hit  = 1'b1;
          cand = cur_slot;
        end else if (WORK_CONSERVING != 0 && fb_hit) begin
          hit  = 1'b1;
          cand = fb_idx;
          rr_d = wrap(int'(fb_idx) + 1);
        end
        if (hit && !reset) begin
          qr[cand] = 1'b1;
          state_d  = BUSY;
          ov_d     = 1'b1;
          oq_d     = cand;
        end
      end
      BUSY: begin
        if (bus.out_ready) begin
          state_d = IDLE;
          ov_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      slot_q  <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      first_q <= 1'b1;
      init_q  <= 1'b1;
      frame_q <= 1'b0;
      ov_q    <= 1'b0;
      oq_q    <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      first_q <= first_d;
      init_q  <= init_d;
      frame_q <= frame_d;
      ov_q    <= ov_d;
      oq_q    <= oq_d;
      rr_q    <= rr_d;
    end
  end

  assign bus.queue_ready = qr;
  assign bus.out_valid   = ov_q;
  assign bus.out_queue   = oq_q;
  assign bus.slot        = reset ? '0 : cur_slot;
  assign bus.frame_start = !reset
                        && (init_q ? |nz : frame_q);
endmodule
